vga_timing_gen: RTL and testbench

Generates VGA raster timing: pixel-rate enable, horizontal/vertical position counters, active-low sync pulses and the display-active flag. It is the producer side of the timing interface consumed by the colour generator, which registers RGB from bright, h_count and v_count. Default timing is 640x480 @ 60 Hz from a 50 MHz clock (25 MHz pixel rate).

---
 rtl/vga_pkg.sv | 31 +++
 rtl/vga_axis_counter.sv | 49 ++++
 rtl/vga_timing_gen.sv | 123 ++++++++++++
 tb/tb_vga_timing_gen.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants: default 640x480@60 geometry, derived totals and sync windows.
package vga_pkg;

    localparam int unsigned COUNT_W = 10;

    localparam int unsigned DEF_PIX_DIV   = 2;
    localparam int unsigned DEF_H_VISIBLE = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;
    localparam int unsigned DEF_V_VISIBLE = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;

    function automatic int unsigned axis_total(input int unsigned visible, input int unsigned front,
                                               input int unsigned sync, input int unsigned back);
        return visible + front + sync + back;
    endfunction

    localparam int unsigned H_TOTAL =
        axis_total(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
    localparam int unsigned V_TOTAL =
        axis_total(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

    localparam int unsigned H_SYNC_START = DEF_H_VISIBLE + DEF_H_FRONT;
    localparam int unsigned H_SYNC_END   = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC - 1;
    localparam int unsigned V_SYNC_START = DEF_V_VISIBLE + DEF_V_FRONT;
    localparam int unsigned V_SYNC_END   = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC - 1;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap strobe and decodes of the next-cycle position.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned VISIBLE = DEF_H_VISIBLE,
    parameter int unsigned FRONT   = DEF_H_FRONT,
    parameter int unsigned SYNC    = DEF_H_SYNC,
    parameter int unsigned BACK    = DEF_H_BACK
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    output logic [COUNT_W-1:0] count,
    output logic               wrap,
    output logic               sync_n_next,
    output logic               active_next
);

    localparam int unsigned TOTAL = axis_total(VISIBLE, FRONT, SYNC, BACK);

    localparam logic [COUNT_W-1:0] LAST_VAL   = COUNT_W'(TOTAL - 1);
    localparam logic [COUNT_W-1:0] SYNC_START = COUNT_W'(VISIBLE + FRONT);
    localparam logic [COUNT_W-1:0] SYNC_END   = COUNT_W'(VISIBLE + FRONT + SYNC - 1);
    localparam logic [COUNT_W-1:0] VIS_END    = COUNT_W'(VISIBLE);

    logic [COUNT_W-1:0] count_q, count_d;

    always_comb begin
        wrap    = enable && (count_q == LAST_VAL);
        count_d = count_q;
        if (enable) begin
            count_d = wrap ? '0 : count_q + 1'b1;
        end
        // Decodes look at count_d so registered outputs line up with the counter they describe.
        sync_n_next = !((count_d >= SYNC_START) && (count_d <= SYNC_END));
        active_next = (count_d < VIS_END);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel enable, h/v counters, active-low syncs, bright, frame_start.
// Define VGA_SYNC_PIPE_EN to delay hsync/vsync by one clock to match a registered RGB path.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned PIX_DIV   = DEF_PIX_DIV,
    parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BACK    = DEF_H_BACK,
    parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BACK    = DEF_V_BACK
) (
    input  logic               clock,
    input  logic               reset,
    output logic               pix_en,
    output logic [COUNT_W-1:0] h_count,
    output logic [COUNT_W-1:0] v_count,
    output logic               hsync,
    output logic               vsync,
    output logic               bright,
    output logic               frame_start
);

    localparam int unsigned DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;

    logic h_wrap, h_sync_n_next, h_active_next;
    logic v_wrap, v_sync_n_next, v_active_next;
    logic v_enable;

    logic hsync_q, vsync_q, bright_q, frame_start_q;
    logic hsync_d, vsync_d, bright_d, frame_start_d;

    // With PIX_DIV == 1 div_q never leaves 0, so pix_en is constantly high.
    always_comb begin
        pix_en = (div_q == DIV_LAST);
        div_d  = pix_en ? '0 : div_q + 1'b1;
    end

    assign v_enable = pix_en & h_wrap;

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK)
    ) u_h_axis (
        .clock       (clock),
        .reset       (reset),
        .enable      (pix_en),
        .count       (h_count),
        .wrap        (h_wrap),
        .sync_n_next (h_sync_n_next),
        .active_next (h_active_next)
    );

    vga_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK)
    ) u_v_axis (
        .clock       (clock),
        .reset       (reset),
        .enable      (v_enable),
        .count       (v_count),
        .wrap        (v_wrap),
        .sync_n_next (v_sync_n_next),
        .active_next (v_active_next)
    );

    always_comb begin
        hsync_d       = h_sync_n_next;
        vsync_d       = v_sync_n_next;
        bright_d      = h_active_next & v_active_next;
        frame_start_d = h_wrap & v_wrap;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_q         <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            bright_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            bright_q      <= bright_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_SYNC_PIPE_EN
    logic hsync_pipe_q, vsync_pipe_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hsync_pipe_q <= 1'b1;
            vsync_pipe_q <= 1'b1;
        end else begin
            hsync_pipe_q <= hsync_q;
            vsync_pipe_q <= vsync_q;
        end
    end

    assign hsync = hsync_pipe_q;
    assign vsync = vsync_pipe_q;
`else
    assign hsync = hsync_q;
    assign vsync = vsync_q;
`endif

    assign bright      = bright_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default timing, PIX_DIV=1 and a shrunken frame geometry.
module tb_vga_timing_gen;

`ifdef VGA_SYNC_PIPE_EN
    localparam int SYNC_LAG = 1;
`else
    localparam int SYNC_LAG = 0;
`endif

    logic clock;
    logic reset;

    logic       pix_en, hsync, vsync, bright, frame_start;
    logic [9:0] h_count, v_count;
    logic       pix_en1, hsync1, vsync1, bright1, frame_start1;
    logic [9:0] h_count1, v_count1;
    logic       pix_en_s, hsync_s, vsync_s, bright_s, frame_start_s;
    logic [9:0] h_count_s, v_count_s;

    int n_checks = 0;
    int n_errors = 0;

    vga_timing_gen dut (
        .clock       (clock),
        .reset       (reset),
        .pix_en      (pix_en),
        .h_count     (h_count),
        .v_count     (v_count),
        .hsync       (hsync),
        .vsync       (vsync),
        .bright      (bright),
        .frame_start (frame_start)
    );

    vga_timing_gen #(.PIX_DIV(1)) dut1 (
        .clock       (clock),
        .reset       (reset),
        .pix_en      (pix_en1),
        .h_count     (h_count1),
        .v_count     (v_count1),
        .hsync       (hsync1),
        .vsync       (vsync1),
        .bright      (bright1),
        .frame_start (frame_start1)
    );

    // 15 x 8 raster at PIX_DIV=2: 30 clocks/line, 240 clocks/frame; hsync h=10..12, vsync v=5..6.
    vga_timing_gen #(
        .PIX_DIV   (2),
        .H_VISIBLE (8),
        .H_FRONT   (2),
        .H_SYNC    (3),
        .H_BACK    (2),
        .V_VISIBLE (4),
        .V_FRONT   (1),
        .V_SYNC    (2),
        .V_BACK    (1)
    ) dut_s (
        .clock       (clock),
        .reset       (reset),
        .pix_en      (pix_en_s),
        .h_count     (h_count_s),
        .v_count     (v_count_s),
        .hsync       (hsync_s),
        .vsync       (vsync_s),
        .bright      (bright_s),
        .frame_start (frame_start_s)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int  n;
        bit  found;
        apply_reset();
        n_checks++; if (h_count !== 10'd0) begin n_errors++; $display("FAIL rst_h got %0d want 0", h_count); end
        n_checks++; if (v_count !== 10'd0) begin n_errors++; $display("FAIL rst_v got %0d want 0", v_count); end
        n_checks++; if (hsync !== 1'b1) begin n_errors++; $display("FAIL rst_hsync got %b want 1", hsync); end
        n_checks++; if (vsync !== 1'b1) begin n_errors++; $display("FAIL rst_vsync got %b want 1", vsync); end
        n_checks++; if (bright !== 1'b0) begin n_errors++; $display("FAIL rst_bright got %b want 0", bright); end
        n_checks++; if (frame_start !== 1'b0) begin n_errors++; $display("FAIL rst_fs got %b want 0", frame_start); end
        n_checks++; if (pix_en !== 1'b0) begin n_errors++; $display("FAIL rst_pix_en got %b want 0", pix_en); end
        @(negedge clock);
        n_checks++; if (bright !== 1'b1) begin n_errors++; $display("FAIL first_edge_bright got %b want 1", bright); end
        n_checks++; if (frame_start !== 1'b0) begin n_errors++; $display("FAIL first_edge_fs got %b want 0", frame_start); end
        n_checks++; if (h_count !== 10'd0) begin n_errors++; $display("FAIL first_edge_h got %0d want 0", h_count); end
        n_checks++; if (pix_en !== 1'b1) begin n_errors++; $display("FAIL first_edge_pix_en got %b want 1", pix_en); end
        @(negedge clock);
        n_checks++; if (h_count !== 10'd1) begin n_errors++; $display("FAIL first_adv_h got %0d want 1", h_count); end
        n_checks++; if (pix_en !== 1'b0) begin n_errors++; $display("FAIL first_adv_pix_en got %b want 0", pix_en); end
        found = 0;
        for (n = 0; n < 1000 && !found; n++) begin
            @(negedge clock);
            if (h_count == 10'd300) found = 1;
        end
        n_checks++; if (!found) begin n_errors++; $display("FAIL reach_h300 got timeout want h=300"); end
        // Assert reset while the clock is low: outputs must clear before the next rising edge.
        #2 reset = 1'b1;
        #1;
        n_checks++; if (h_count !== 10'd0) begin n_errors++; $display("FAIL async_h got %0d want 0", h_count); end
        n_checks++; if (v_count !== 10'd0) begin n_errors++; $display("FAIL async_v got %0d want 0", v_count); end
        n_checks++; if (bright !== 1'b0) begin n_errors++; $display("FAIL async_bright got %b want 0", bright); end
        n_checks++; if (hsync !== 1'b1 || vsync !== 1'b1) begin
            n_errors++; $display("FAIL async_sync got %b%b want 11", hsync, vsync);
        end
        n_checks++; if (h_count_s !== 10'd0 || v_count_s !== 10'd0 || bright_s !== 1'b0) begin
            n_errors++; $display("FAIL async_small got h=%0d v=%0d b=%b want 0 0 0", h_count_s, v_count_s, bright_s);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_line();
        int hs_low, br_hi, pe_hi, align_err, line_clk, fall_h;
        logic [9:0] prev_h, hx;
        logic exp_hs;
        bit seen_fall;
        hs_low = 0; br_hi = 0; pe_hi = 0; align_err = 0; line_clk = 0; fall_h = -1;
        seen_fall = 0; prev_h = 0;
        apply_reset();
        for (int i = 1; i <= 1600; i++) begin
            @(negedge clock);
            if (!hsync) hs_low++;
            if (bright) br_hi++;
            if (pix_en) pe_hi++;
            hx = (SYNC_LAG != 0) ? prev_h : h_count;
            exp_hs = !(hx >= 10'd656 && hx <= 10'd751);
            if (hsync !== exp_hs) align_err++;
            if (bright !== (h_count < 10'd640 && v_count < 10'd480)) align_err++;
            if (!hsync && !seen_fall) begin seen_fall = 1; fall_h = h_count; end
            if (v_count == 10'd1 && line_clk == 0) line_clk = i;
            prev_h = h_count;
        end
        n_checks++; if (hs_low != 192) begin n_errors++; $display("FAIL line_hsync_low got %0d want 192", hs_low); end
        n_checks++; if (br_hi != 1280) begin n_errors++; $display("FAIL line_bright got %0d want 1280", br_hi); end
        n_checks++; if (pe_hi != 800) begin n_errors++; $display("FAIL line_pix_en got %0d want 800", pe_hi); end
        n_checks++; if (align_err != 0) begin n_errors++; $display("FAIL line_align got %0d want 0", align_err); end
        n_checks++; if (line_clk != 1600) begin n_errors++; $display("FAIL line_clocks got %0d want 1600", line_clk); end
        n_checks++; if (fall_h != 656) begin n_errors++; $display("FAIL line_hsync_fall_h got %0d want 656", fall_h); end
        n_checks++; if (h_count !== 10'd0 || v_count !== 10'd1) begin
            n_errors++; $display("FAIL line_end got h=%0d v=%0d want 0 1", h_count, v_count);
        end
    endtask

    task automatic test_pix_div1();
        int pe_lo, hs_low, br_hi, align_err, line_clk, fall_h;
        logic [9:0] prev_h, hx;
        logic exp_hs;
        bit seen_fall;
        pe_lo = 0; hs_low = 0; br_hi = 0; align_err = 0; line_clk = 0; fall_h = -1;
        seen_fall = 0; prev_h = 0;
        apply_reset();
        for (int i = 1; i <= 800; i++) begin
            @(negedge clock);
            if (!pix_en1) pe_lo++;
            if (!hsync1) hs_low++;
            if (bright1) br_hi++;
            hx = (SYNC_LAG != 0) ? prev_h : h_count1;
            exp_hs = !(hx >= 10'd656 && hx <= 10'd751);
            if (hsync1 !== exp_hs) align_err++;
            if (bright1 !== (h_count1 < 10'd640 && v_count1 < 10'd480)) align_err++;
            if (!hsync1 && !seen_fall) begin seen_fall = 1; fall_h = h_count1; end
            if (v_count1 == 10'd1 && line_clk == 0) line_clk = i;
            prev_h = h_count1;
        end
        n_checks++; if (pe_lo != 0) begin n_errors++; $display("FAIL div1_pix_en_low got %0d want 0", pe_lo); end
        n_checks++; if (hs_low != 96) begin n_errors++; $display("FAIL div1_hsync_low got %0d want 96", hs_low); end
        n_checks++; if (br_hi != 640) begin n_errors++; $display("FAIL div1_bright got %0d want 640", br_hi); end
        n_checks++; if (align_err != 0) begin n_errors++; $display("FAIL div1_align got %0d want 0", align_err); end
        n_checks++; if (line_clk != 800) begin n_errors++; $display("FAIL div1_line_clocks got %0d want 800", line_clk); end
        n_checks++; if (fall_h != 656 + SYNC_LAG) begin
            n_errors++; $display("FAIL div1_hsync_fall_h got %0d want %0d", fall_h, 656 + SYNC_LAG);
        end
    endtask

    task automatic test_frame();
        int fs_cnt, fs_first, fs_second, fs_wide, vs_low, max_h, max_v;
        logic [9:0] h239, v239, h240, v240;
        logic pe239, fs240, br240, prev_fs;
        fs_cnt = 0; fs_first = 0; fs_second = 0; fs_wide = 0; vs_low = 0; max_h = 0; max_v = 0;
        prev_fs = 0; h239 = 'x; v239 = 'x; h240 = 'x; v240 = 'x; pe239 = 'x; fs240 = 'x; br240 = 'x;
        apply_reset();
        for (int i = 1; i <= 500; i++) begin
            @(negedge clock);
            if (frame_start_s) begin
                fs_cnt++;
                if (fs_cnt == 1) fs_first = i;
                if (fs_cnt == 2) fs_second = i;
                if (prev_fs) fs_wide++;
            end
            prev_fs = frame_start_s;
            if (i <= 480 && !vsync_s) vs_low++;
            if (int'(h_count_s) > max_h) max_h = int'(h_count_s);
            if (int'(v_count_s) > max_v) max_v = int'(v_count_s);
            if (i == 239) begin h239 = h_count_s; v239 = v_count_s; pe239 = pix_en_s; end
            if (i == 240) begin
                h240 = h_count_s; v240 = v_count_s; fs240 = frame_start_s; br240 = bright_s;
            end
        end
        n_checks++; if (fs_cnt != 2) begin n_errors++; $display("FAIL frame_fs_count got %0d want 2", fs_cnt); end
        n_checks++; if (fs_first != 240) begin n_errors++; $display("FAIL frame_fs_first got %0d want 240", fs_first); end
        n_checks++; if (fs_second - fs_first != 240) begin
            n_errors++; $display("FAIL frame_fs_period got %0d want 240", fs_second - fs_first);
        end
        n_checks++; if (fs_wide != 0) begin n_errors++; $display("FAIL frame_fs_width got %0d want 0", fs_wide); end
        n_checks++; if (vs_low != 120) begin n_errors++; $display("FAIL frame_vsync_low got %0d want 120", vs_low); end
        n_checks++; if (h239 !== 10'd14 || v239 !== 10'd7 || pe239 !== 1'b1) begin
            n_errors++; $display("FAIL frame_pre_wrap got h=%0d v=%0d pe=%b want 14 7 1", h239, v239, pe239);
        end
        n_checks++; if (h240 !== 10'd0 || v240 !== 10'd0) begin
            n_errors++; $display("FAIL frame_wrap_pos got h=%0d v=%0d want 0 0", h240, v240);
        end
        n_checks++; if (fs240 !== 1'b1 || br240 !== 1'b1) begin
            n_errors++; $display("FAIL frame_wrap_flags got fs=%b br=%b want 1 1", fs240, br240);
        end
        n_checks++; if (max_h != 14 || max_v != 7) begin
            n_errors++; $display("FAIL frame_max got h=%0d v=%0d want 14 7", max_h, max_v);
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_line();
        test_pix_div1();
        test_frame();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
